// File: rtl/arb_pkg.sv
// Shared types and widths for the req_arb8 eight-requester arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int ID_W   = 3;
  localparam int HCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the rotate input moves the top-priority slot
// so that the search runs rot-1, rot-2, ... down to rot (rot=0 gives plain 7..0).
module prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rot,
  output logic [ID_W-1:0]  idx,
  output logic             vld
);

  logic [ID_W-1:0] pos;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
    pos = '0;
    vld = |req;
    // Walk from lowest to highest priority; the last hit is the winner.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = rot - ID_W'(k) - ID_W'(1);
      if (req[pos]) idx = pos;
    end
  end

endmodule

// File: rtl/req_arb8.sv
// Eight-requester arbiter with hold timeout and registered one-hot / encoded grant.
// Optional macro ARB_ROUND_ROBIN_EN rotates priority so the last winner becomes lowest.
module req_arb8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam bit                TO_EN     = (MAX_HOLD != 0);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [HCNT_W-1:0] hold_cnt, hold_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic              vld_nxt;
  logic              to_nxt;
  logic [ID_W-1:0]   rot;
  logic [ID_W-1:0]   win;
  logic              win_vld;
  logic              rel_done, rel_drop, rel_to;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     rr_ptr <= '0;
    else if (state == IDLE && en && win_vld)     rr_ptr <= win;
  end

  assign rot = rr_ptr;
`else
  assign rot = '0;
`endif

  prio_enc8 u_enc (
    .req (req),
    .rot (rot),
    .idx (win),
    .vld (win_vld)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    vld_nxt   = gnt_vld;
    to_nxt    = 1'b0;
    rel_done  = 1'b0;
    rel_drop  = 1'b0;
    rel_to    = 1'b0;
    case (state)
      IDLE: begin
        if (en && win_vld) begin
          state_nxt = GRANT;
          hold_nxt  = '0;
          gnt_nxt   = N_REQ'(1) << win;
          id_nxt    = win;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        rel_done = done;
        rel_drop = !req[gnt_id];
        rel_to   = TO_EN && (hold_cnt == HOLD_LAST);
        if (rel_done || rel_drop || rel_to) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
          gnt_nxt   = '0;
          id_nxt    = '0;
          vld_nxt   = 1'b0;
          // A timeout is only flagged when nothing else caused the release.
          to_nxt    = rel_to && !rel_done && !rel_drop;
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + HCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      gnt_vld  <= vld_nxt;
      timeout  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_req_arb8.sv
// Scoreboard bench for req_arb8: directed scenarios plus random traffic against a
// cycle-level reference model of grant ownership.
module tb_req_arb8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  req_arb8 #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who owns the resource and for how many cycles so far.
  int   owner = -1;
  int   held  = 0;
  int   last  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    int w;
    w = -1;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 8; k >= 1; k--)
      if (r[(p - k + 8) % 8]) w = (p - k + 8) % 8;
`else
    for (int c = 0; c < 8; c++)
      if (r[c]) w = c;
`endif
    return w;
  endfunction

  task automatic model_edge(input logic e, input logic [7:0] r, input logic d);
    exp_t x;
    bit   lim;
    x.to = 1'b0;
    if (owner < 0) begin
      if (e && r != 8'h00) begin
        owner = pick(r, last);
        last  = owner;
        held  = 1;
      end
    end else begin
      lim = (MAXH != 0) && (held == MAXH);
      if (d || !r[owner] || lim) begin
        x.to  = lim && !d && r[owner];
        owner = -1;
      end else begin
        held++;
      end
    end
    x.vld = (owner >= 0);
    x.gnt = (owner >= 0) ? 8'(1 << owner) : 8'h00;
    x.id  = (owner >= 0) ? 3'(owner) : 3'd0;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic e, input logic [7:0] r, input logic d);
    @(negedge clk);
    en = e; req = r; done = d;
    model_edge(e, r, d);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en = 1'b0; req = 8'h00; done = 1'b0;
    rst = 1'b1;
    owner = -1; held = 0; last = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
      check("vld_eq_gnt", 32'(gnt_vld), 32'(gnt != 8'h00));
      check("id_match", 32'(gnt_vld ? (8'(1) << gnt_id) : {5'd0, gnt_id}), 32'(gnt_vld ? gnt : 8'h00));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_gnt", 32'(gnt), 32'(e.gnt));
        check("sb_id", 32'(gnt_id), 32'(e.id));
        check("sb_vld", 32'(gnt_vld), 32'(e.vld));
        check("sb_to", 32'(timeout), 32'(e.to));
      end
    end
  end

  initial begin
    logic [7:0] r;
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    #12;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_to", 32'(timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a grant.
    step(1'b1, 8'hFF, 1'b0);
    settle();
    check("pre_rst_vld", 32'(gnt_vld), 32'd1);
    en = 1'b0; req = 8'h00;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_vld", 32'(gnt_vld), 32'd0);
    apply_reset();

    // Priority, then done release and one dead cycle.
    step(1'b1, 8'b0010_1100, 1'b0);
    settle();
    check("prio_gnt", 32'(gnt), 32'h20);
    check("prio_id", 32'(gnt_id), 32'd5);
    check("prio_vld", 32'(gnt_vld), 32'd1);
    step(1'b1, 8'b0010_1100, 1'b0);
    step(1'b1, 8'b0010_1100, 1'b1);
    settle();
    check("done_rel", 32'(gnt), 32'd0);
    step(1'b1, 8'b0000_1100, 1'b0);
    settle();
    check("next_id3", 32'(gnt_id), 32'd3);
    step(1'b1, 8'b0000_1100, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Hold timeout: four granted cycles, then a timeout pulse on the dead cycle.
    step(1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("to_hold_vld", 32'(gnt_vld), 32'd1);
      step(1'b1, 8'h04, 1'b0);
    end
    settle();
    check("to_hold_last", 32'(gnt_vld), 32'd1);
    step(1'b1, 8'h04, 1'b0);
    settle();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_dead", 32'(gnt_vld), 32'd0);
    step(1'b1, 8'h04, 1'b0);
    settle();
    check("to_regrant", 32'(gnt_id), 32'd2);
    check("to_cleared", 32'(timeout), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b1);
    settle();
    check("to_done_wins", 32'(timeout), 32'd0);
    step(1'b0, 8'h00, 1'b0);

    // Request drop releases without timeout; en low does not abort a grant.
    step(1'b1, 8'h40, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    settle();
    check("drop_rel", 32'(gnt_vld), 32'd0);
    check("drop_no_to", 32'(timeout), 32'd0);
    step(1'b1, 8'h40, 1'b0);
    step(1'b0, 8'h40, 1'b0);
    step(1'b0, 8'h40, 1'b0);
    settle();
    check("en_low_keeps", 32'(gnt_id), 32'd6);
    step(1'b0, 8'h40, 1'b1);
    step(1'b0, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    settle();
    check("en_low_idle", 32'(gnt_vld), 32'd0);

    // Fairness sequence from reset.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      check("rr_seq", 32'(gnt_id), 32'((15 - i) % 8));
`else
      check("fixed_seq", 32'(gnt_id), 32'd7);
`endif
      step(1'b1, 8'hFF, 1'b1);
    end

    // Random traffic checked only by the scoreboard.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      step($urandom_range(0, 7) != 0, r, $urandom_range(0, 6) == 0);
    end
    step(1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
